// File: rtl/led_blink_scheduler.sv
// LED bank pattern sequencer with prescaled step tick.
// Start/stop and mode changes go through a small IDLE/RUN/SWITCH FSM.
module led_blink_scheduler #(
  parameter int TICK_DIV = 25000000,
  parameter int N_LED    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [1:0]       mode_sel,
  input  logic             mode_req,
  output logic             mode_ack,
  output logic [N_LED-1:0] led,
  output logic             tick,
  output logic             busy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;

  localparam logic [1:0] M_ALL    = 2'd0;
  localparam logic [1:0] M_CHASE  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_COUNT  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       mode;
  logic [1:0]       mode_nx;
  logic [PW-1:0]    presc;
  logic             dir_right;
  logic             step_dir;
  logic [N_LED-1:0] init_led;
  logic [N_LED-1:0] step_led;

  // A request at the same edge as a RUN entry must start the new pattern.
  assign mode_nx = mode_req ? mode_sel : mode;
  assign busy    = (state != IDLE);
  assign tick    = (state == RUN) && (presc == LAST);

  // Initial LED value of the pattern about to start.
  always_comb begin
    init_led = '0;
    case (mode_nx)
      M_CHASE:  init_led = N_LED'(1);
      M_BOUNCE: init_led = N_LED'(1);
      default:  init_led = '0;
    endcase
  end

  // Next LED value and bounce direction for one pattern step.
  always_comb begin
    step_led = led;
    step_dir = dir_right;
    case (mode)
      M_ALL:   step_led = ~led;
      M_CHASE: step_led = {led[N_LED-2:0], led[N_LED-1]};
      M_BOUNCE: begin
        if (!dir_right) begin
          step_led = led << 1;
          if (step_led[N_LED-1]) step_dir = 1'b1;
        end else begin
          step_led = led >> 1;
          if (step_led[0]) step_dir = 1'b0;
        end
      end
      M_COUNT: step_led = led + N_LED'(1);
      default: step_led = led;
    endcase
  end

  // Mode register and acknowledge pulse, independent of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= M_ALL;
      mode_ack <= 1'b0;
    end else begin
      mode_ack <= mode_req;
      if (mode_req) mode <= mode_sel;
    end
  end

  // FSM, prescaler and LED register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      led       <= '0;
      dir_right <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          presc <= '0;
          led   <= '0;
          if (run) begin
            state     <= RUN;
            led       <= init_led;
            dir_right <= 1'b0;
          end
        end
        RUN: begin
          if (!run) begin
            state <= IDLE;
            presc <= '0;
            led   <= '0;
          end else if (mode_req) begin
            state <= SWITCH;
            presc <= '0;
            led   <= '0;
          end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
              led       <= step_led;
              dir_right <= step_dir;
            end
          end
        end
        SWITCH: begin
          presc <= '0;
          led   <= '0;
          if (!run) begin
            state <= IDLE;
          end else if (mode_req) begin
            state <= SWITCH;
          end else begin
            state     <= RUN;
            led       <= init_led;
            dir_right <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          presc <= '0;
          led   <= '0;
        end
      endcase
    end
  end

endmodule
